// File: rtl/riscv_cu_hs.sv
// Multi-cycle RISC-V control unit with a memory ready handshake, a bounded wait-state timeout and a sticky fault state.
// Optional feature: define RISCV_CU_HALT_EN to send SYSTEM opcodes to an absorbing HALT state instead of FAULT.
module riscv_cu_hs #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_WE,
    output logic       addr_reg_WE,
    output logic       data_reg_WE,
    output logic       inst_reg_WE,
    output logic       grg_WE,
    output logic       mem_RE,
    output logic       mem_WE,
    output logic       mem_timeout,
    output logic       illegal_inst,
    output logic       halted,
    output logic [3:0] cur_state
);

    localparam int CNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        F_ADDR  = 4'd1,
        F_READ  = 4'd2,
        DECODE  = 4'd3,
        EXEC_WB = 4'd4,
        EXEC_B  = 4'd5,
        S_ADDR  = 4'd6,
        S_DATA  = 4'd7,
        S_WRITE = 4'd8,
        L_ADDR  = 4'd9,
        L_READ  = 4'd10,
        L_WB    = 4'd11,
        FAULT   = 4'd12,
        HALT    = 4'd13
    } state_e;

    state_e           state_q, state_d;
    state_e           wait_next;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             illegal_q, illegal_d;
    logic             halted_q, halted_d;
    // Enable vector order: {pc, addr_reg, data_reg, inst_reg, grg, mem_RE, mem_WE}
    logic [6:0]       en_q, en_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        illegal_d  = illegal_q;
        halted_d   = halted_q;
        wait_next  = (state_q == F_READ) ? DECODE :
                     (state_q == L_READ) ? L_WB : F_ADDR;

        case (state_q)
            IDLE:    state_d = F_ADDR;
            F_ADDR:  begin
                state_d    = F_READ;
                wait_cnt_d = '0;
            end
            F_READ, L_READ, S_WRITE: begin
                if (mem_ready) begin
                    state_d    = wait_next;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = FAULT;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    7'b0110011, 7'b0010011, 7'b1101111,
                    7'b1100111, 7'b0110111, 7'b0010111: state_d = EXEC_WB;
                    7'b1100011: state_d = EXEC_B;
                    7'b0100011: state_d = S_ADDR;
                    7'b0000011: state_d = L_ADDR;
`ifdef RISCV_CU_HALT_EN
                    7'b1110011: begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
`endif
                    default: begin
                        state_d   = FAULT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC_WB, EXEC_B, L_WB: state_d = F_ADDR;
            S_ADDR:  state_d = S_DATA;
            S_DATA:  begin
                state_d    = S_WRITE;
                wait_cnt_d = '0;
            end
            L_ADDR:  begin
                state_d    = L_READ;
                wait_cnt_d = '0;
            end
            FAULT, HALT: state_d = state_q;
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next state so they are registered alongside it.
    always_comb begin
        en_d = 7'b0000000;
        case (state_d)
            F_ADDR:  en_d = 7'b0100000;
            F_READ:  en_d = 7'b0010010;
            DECODE:  en_d = 7'b0001000;
            EXEC_WB: en_d = 7'b1000100;
            EXEC_B:  en_d = 7'b1000000;
            S_ADDR:  en_d = 7'b1100000;
            S_DATA:  en_d = 7'b0010000;
            S_WRITE: en_d = 7'b0000001;
            L_ADDR:  en_d = 7'b1100000;
            L_READ:  en_d = 7'b0010010;
            L_WB:    en_d = 7'b0000100;
            default: en_d = 7'b0000000;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
            en_q       <= 7'b0000000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            illegal_q  <= illegal_d;
            halted_q   <= halted_d;
            en_q       <= en_d;
        end
    end

    assign {pc_WE, addr_reg_WE, data_reg_WE, inst_reg_WE, grg_WE, mem_RE, mem_WE} = en_q;
    assign mem_timeout  = timeout_q;
    assign illegal_inst = illegal_q;
    assign cur_state    = state_q;

`ifdef RISCV_CU_HALT_EN
    assign halted = halted_q;
`else
    // HALT is unreachable here, so the flag is constant.
    assign halted = 1'b0;
`endif

endmodule

// File: doc/riscv_cu_hs.md
# riscv_cu_hs

Multi-cycle RISC-V control unit with a memory ready handshake, a bounded wait-state timeout, and a sticky fault state. It drives the same register and memory write/read enables as the current fixed-timing control unit. It replaces that unit in the single-bus datapath so that memory of arbitrary latency can be attached. Illegal opcodes and memory hangs are reported instead of leaving the FSM stuck.

## Interface
- MEM_WAIT_MAX, 15: max extra cycles a memory wait state may stall before faulting; range 0..255. Internal counter width is clog2(MEM_WAIT_MAX+1), minimum 1.
- clk  in  1  clock; all state and outputs update on the falling edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  7  instruction[6:0] from the instruction register.
- mem_ready  in  1  memory has completed the current read or write.
- pc_WE  out  1  PC write enable.
- addr_reg_WE  out  1  address register write enable.
- data_reg_WE  out  1  data register write enable.
- inst_reg_WE  out  1  instruction register write enable.
- grg_WE  out  1  general register file write enable.
- mem_RE  out  1  memory read request.
- mem_WE  out  1  memory write request.
- mem_timeout  out  1  sticky; a wait state exceeded MEM_WAIT_MAX.
- illegal_inst  out  1  sticky; an undecodable opcode was seen.
- halted  out  1  sticky; SYSTEM opcode reached (macro builds only).
- cur_state  out  4  current state encoding, for debug.

## Operation
State encodings and the enables asserted in each state (all other enables are 0):
- IDLE=0: none.
- F_ADDR=1: addr_reg_WE.
- F_READ=2: mem_RE, data_reg_WE. This is a wait state.
- DECODE=3: inst_reg_WE.
- EXEC_WB=4: pc_WE, grg_WE.
- EXEC_B=5: pc_WE.
- S_ADDR=6: pc_WE, addr_reg_WE.
- S_DATA=7: data_reg_WE.
- S_WRITE=8: mem_WE. This is a wait state.
- L_ADDR=9: pc_WE, addr_reg_WE.
- L_READ=10: mem_RE, data_reg_WE. This is a wait state.
- L_WB=11: grg_WE.
- FAULT=12: none.
- HALT=13: none.

Transitions:
- IDLE -> F_ADDR unconditionally.
- F_ADDR -> F_READ.
- S_ADDR -> S_DATA -> S_WRITE.
- L_ADDR -> L_READ.
- L_WB, EXEC_WB and EXEC_B -> F_ADDR.
- DECODE uses the opcode sampled at the falling edge that ends DECODE:
  - 0110011, 0010011, 1101111, 1100111, 0110111, 0010111 -> EXEC_WB.
  - 1100011 -> EXEC_B.
  - 0100011 -> S_ADDR.
  - 0000011 -> L_ADDR.
  - 1110011 -> HALT (macro builds only).
  - Any other opcode -> FAULT, and illegal_inst is set.
- Wait states (F_READ, L_READ, S_WRITE), evaluated at each falling edge while in the state:
  - mem_ready=1 -> advance to DECODE, L_WB or F_ADDR respectively, and clear wait_cnt.
  - mem_ready=0 and wait_cnt==MEM_WAIT_MAX -> FAULT, and mem_timeout is set.
  - Otherwise stay in the state and increment wait_cnt.
- wait_cnt is 0 on entry to every wait state and never wraps.
- FAULT and HALT are absorbing; only rst leaves them. The sticky flags hold until rst.
- mem_RE and mem_WE are held constant for the whole wait state. data_reg_WE stays asserted throughout L_READ and F_READ, so the last written value is the ready cycle's data.

## Timing
- Outputs are registered. They change on the falling edge that enters a state and are constant for that full clock period. The datapath samples them on the rising edge.
- Reset values: state is IDLE, all enables 0, mem_timeout/illegal_inst/halted 0, wait_cnt 0, cur_state 0.
- Assertion of rst clears everything immediately, including in the middle of a wait state.
- After rst deasserts, the first falling edge enters F_ADDR.
- Latency with zero wait (mem_ready held at 1):
  - ALU/jump/upper-immediate instructions take 4 cycles: F_ADDR, F_READ, DECODE, EXEC_WB.
  - Branch takes 4 cycles.
  - Load and store take 6 cycles each.
- Each wait cycle adds 1 cycle. A wait state lasts at most MEM_WAIT_MAX+1 cycles.
- MEM_WAIT_MAX=0 means mem_ready must already be 1 on the first cycle of the wait state.
- mem_ready is ignored outside wait states.

## Configuration
- RISCV_CU_HALT_EN defined:
  - Opcode 1110011 (ECALL/EBREAK) goes to HALT, and halted is set.
- RISCV_CU_HALT_EN undefined:
  - Opcode 1110011 is illegal: the FSM goes to FAULT and sets illegal_inst.
  - halted is tied to 0.
  - The HALT encoding 13 is unreachable.

## Test plan
- Reset, mem_ready=1, opcode=0110011 repeated:
  - cur_state sequence is 0,1,2,3,4,1,2,3,4…
  - pc_WE and grg_WE are high exactly one cycle in four.
- Load (opcode=0000011) with mem_ready low for 3 cycles in L_READ:
  - The instruction takes 9 cycles in total.
  - grg_WE pulses once, one cycle after mem_ready is sampled high.
- MEM_WAIT_MAX=2, mem_ready=0 in F_READ:
  - The FSM stays in F_READ for 3 cycles, then enters FAULT.
  - mem_timeout=1 and all enables stay at 0 thereafter.
- Opcode 1111111 in DECODE:
  - The FSM goes to FAULT with illegal_inst=1.
  - Asserting rst mid-FAULT returns it to IDLE with all flags 0.
- Store with mem_ready=1:
  - Sequence is 1,2,3,6,7,8,1.
  - mem_WE is high only during S_WRITE.
  - pc_WE and addr_reg_WE are high together in S_ADDR.
- Opcode 1110011, built with and without RISCV_CU_HALT_EN:
  - With the macro: HALT, halted=1.
  - Without the macro: FAULT, illegal_inst=1.
